cv32e40x_xif_aes_queue: RTL

Multi-outstanding AES32 (Zkne/Zknd) coprocessor on the eXtension interface (flattened XIF signals). It decodes offloaded aes32esi/esmi/dsi/dsmi, buffers up to DEPTH speculative instructions with their operands, and resolves each entry against commit/kill. It executes committed entries in order on an internal riscv_crypto_fu_saes32 and returns results through a registered, back-pressured result channel. It sits between the cv32e40x core XIF and the AES datapath.

---
 rtl/cv32e40x_xif_aes_queue.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cv32e40x_xif_aes_queue.sv
// cv32e40x_xif_aes_queue: multi-outstanding AES32 (Zkne/Zknd) coprocessor on flattened XIF signals.
// Accepted instructions wait in a DEPTH-entry in-order queue until they are committed or killed.
// Committed heads run through riscv_crypto_fu_saes32 into a registered, back-pressured result port.
// Optional macro XIF_AES_DEC_EN: decodes aes32dsi/aes32dsmi and builds the FU with decryption.

module riscv_crypto_fu_saes32 #(
  parameter bit SAES_DEC_EN = 1'b0
) (
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [1:0]  i_bs,
  input  logic        i_dec,
  input  logic        i_mix,
  output logic [31:0] o_rd
);

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  logic        w_dec;
  logic [7:0]  w_sel;
  logic [7:0]  w_so;
  logic [31:0] w_mix;
  logic [31:0] w_rot;

  // Byte select, S-box, optional MixColumns column, rotate back into place and fold into rs1.
  always_comb begin
    w_dec = SAES_DEC_EN && i_dec;
    case (i_bs)
      2'd0:    w_sel = i_rs2[7:0];
      2'd1:    w_sel = i_rs2[15:8];
      2'd2:    w_sel = i_rs2[23:16];
      default: w_sel = i_rs2[31:24];
    endcase
    if (w_dec) w_so = sbox_inv(w_sel);
    else       w_so = sbox_fwd(w_sel);
    if (!i_mix) w_mix = {24'h000000, w_so};
    else if (w_dec) w_mix = {gf_mul(w_so, 8'h0b), gf_mul(w_so, 8'h0d), gf_mul(w_so, 8'h09), gf_mul(w_so, 8'h0e)};
    else w_mix = {gf_mul(w_so, 8'h03), w_so, w_so, gf_xtime(w_so)};
    case (i_bs)
      2'd0:    w_rot = w_mix;
      2'd1:    w_rot = {w_mix[23:0], w_mix[31:24]};
      2'd2:    w_rot = {w_mix[15:0], w_mix[31:16]};
      default: w_rot = {w_mix[7:0],  w_mix[31:8]};
    endcase
    o_rd = i_rs1 ^ w_rot;
  end

endmodule

module cv32e40x_xif_aes_queue #(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_issue_valid,
  output logic                  o_issue_ready,
  input  logic [31:0]           i_issue_instr,
  input  logic [X_ID_WIDTH-1:0] i_issue_id,
  input  logic [XLEN-1:0]       i_issue_rs0,
  input  logic [XLEN-1:0]       i_issue_rs1,
  input  logic [1:0]            i_issue_rs_valid,
  output logic                  o_issue_accept,
  output logic                  o_issue_writeback,
  input  logic                  i_commit_valid,
  input  logic [X_ID_WIDTH-1:0] i_commit_id,
  input  logic                  i_commit_kill,
  output logic                  o_result_valid,
  input  logic                  i_result_ready,
  output logic [X_ID_WIDTH-1:0] o_result_id,
  output logic [XLEN-1:0]       o_result_data,
  output logic [4:0]            o_result_rd,
  output logic                  o_result_we
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW:0]     LP_DEPTH = (PW+1)'(DEPTH);
  localparam logic [PW-1:0]   LP_P_ONE = PW'(1);
  localparam logic [PW:0]     LP_C_ONE = (PW+1)'(1);
`ifdef XIF_AES_DEC_EN
  localparam bit              LP_DEC_EN = 1'b1;
`else
  localparam bit              LP_DEC_EN = 1'b0;
`endif

  // Queue payload; r_op is {decrypt, mixcolumn}.
  logic [X_ID_WIDTH-1:0] r_id  [DEPTH];
  logic [XLEN-1:0]       r_rs0 [DEPTH];
  logic [XLEN-1:0]       r_rs1 [DEPTH];
  logic [1:0]            r_bs  [DEPTH];
  logic [1:0]            r_op  [DEPTH];
  logic [4:0]            r_rd  [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  logic [DEPTH-1:0]      r_cmt;
  logic [DEPTH-1:0]      r_kil;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [PW:0]           r_count;

  logic                  r_res_valid;
  logic [X_ID_WIDTH-1:0] r_res_id;
  logic [XLEN-1:0]       r_res_data;
  logic [4:0]            r_res_rd;
  logic                  r_res_we;

  logic        w_is_aes;
  logic        w_not_full;
  logic        w_push;
  logic        w_head_vld;
  logic        w_pop_kill;
  logic        w_pop_res;
  logic        w_pop;
  logic        w_new_match;
  logic [31:0] w_fu_rd;
  logic        w_unused;

  assign w_unused = ^i_issue_instr[24:15];

  // Decode the four AES32 encodings; decryption forms only when the decrypt option is built in.
  always_comb begin
    w_is_aes = 1'b0;
    if ((i_issue_instr[6:0] == 7'b0110011) && (i_issue_instr[14:12] == 3'b000)) begin
      case (i_issue_instr[29:25])
        5'b10001, 5'b10011: w_is_aes = 1'b1;
`ifdef XIF_AES_DEC_EN
        5'b10101, 5'b10111: w_is_aes = 1'b1;
`endif
        default:            w_is_aes = 1'b0;
      endcase
    end else begin
      w_is_aes = 1'b0;
    end
  end

  assign w_not_full = (r_count != LP_DEPTH);

  // Issue handshake: AES needs a free slot and both operands; anything else is refused at once.
  always_comb begin
    o_issue_ready     = 1'b0;
    o_issue_accept    = 1'b0;
    o_issue_writeback = 1'b0;
    if (!rst_n) begin
      o_issue_ready = 1'b0;
    end else if (w_is_aes) begin
      o_issue_ready     = w_not_full && (i_issue_rs_valid == 2'b11);
      o_issue_accept    = i_issue_valid;
      o_issue_writeback = i_issue_valid;
    end else begin
      o_issue_ready = 1'b1;
    end
  end

  assign w_push      = i_issue_valid && o_issue_ready && w_is_aes;
  assign w_new_match = i_commit_valid && (i_commit_id == i_issue_id);
  assign w_head_vld  = r_vld[r_head];
  assign w_pop_kill  = w_head_vld && r_kil[r_head];
  assign w_pop_res   = w_head_vld && !r_kil[r_head] && r_cmt[r_head] && (!r_res_valid || i_result_ready);
  assign w_pop       = w_pop_kill || w_pop_res;

  riscv_crypto_fu_saes32 #(
    .SAES_DEC_EN (LP_DEC_EN)
  ) u_fu (
    .i_rs1 (r_rs0[r_head]),
    .i_rs2 (r_rs1[r_head]),
    .i_bs  (r_bs[r_head]),
    .i_dec (r_op[r_head][1]),
    .i_mix (r_op[r_head][0]),
    .o_rd  (w_fu_rd)
  );

  // Entry payload; only meaningful while the matching valid flag is set.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_id[r_tail]  <= i_issue_id;
      r_rs0[r_tail] <= i_issue_rs0;
      r_rs1[r_tail] <= i_issue_rs1;
      r_bs[r_tail]  <= i_issue_instr[31:30];
      r_op[r_tail]  <= i_issue_instr[27:26];
      r_rd[r_tail]  <= i_issue_instr[11:7];
    end
  end

  // Entry flags and pointers: commit/kill marking, in-order pop at head, push at tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_cmt   <= '0;
      r_kil   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_commit_valid && r_vld[i] && (r_id[i] == i_commit_id)) begin
          if (i_commit_kill) r_kil[i] <= 1'b1;
          else               r_cmt[i] <= 1'b1;
        end
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_cmt[r_head] <= 1'b0;
        r_kil[r_head] <= 1'b0;
        r_head        <= r_head + LP_P_ONE;
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_cmt[r_tail] <= w_new_match && !i_commit_kill;
        r_kil[r_tail] <= w_new_match && i_commit_kill;
        r_tail        <= r_tail + LP_P_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_C_ONE;
        2'b01:   r_count <= r_count - LP_C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Result register: loads on a committed pop, holds until the core takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
      r_res_rd    <= 5'd0;
      r_res_we    <= 1'b0;
    end else if (w_pop_res) begin
      r_res_valid <= 1'b1;
      r_res_id    <= r_id[r_head];
      r_res_data  <= w_fu_rd;
      r_res_rd    <= r_rd[r_head];
      r_res_we    <= 1'b1;
    end else if (i_result_ready) begin
      r_res_valid <= 1'b0;
      r_res_we    <= 1'b0;
    end
  end

  assign o_result_valid = r_res_valid;
  assign o_result_id    = r_res_id;
  assign o_result_data  = r_res_data;
  assign o_result_rd    = r_res_rd;
  assign o_result_we    = r_res_we;

endmodule
